// File: rtl/i2c_master_byte_seq_pkg.sv
// Shared constants for the I2C byte sequencer: bit-controller command codes,
// watchdog counter width and a small command helper.
package i2c_master_byte_seq_pkg;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    localparam int WD_WIDTH = 16;

    function automatic logic is_bus_cmd(input logic [3:0] cmd);
        return (cmd != I2C_CMD_NOP);
    endfunction

endpackage

// File: rtl/i2c_master_byte_seq_watchdog.sv
// Per-bit-command watchdog for the byte sequencer; only built when
// I2C_SEQ_TIMEOUT_EN is defined.
`ifdef I2C_SEQ_TIMEOUT_EN
module i2c_seq_watchdog
    import i2c_master_byte_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic busy,
    output logic expired
);

    logic [WD_WIDTH-1:0] count_q;
    logic [WD_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = WD_WIDTH'(TIMEOUT_CYCLES);
        end else if (busy && (count_q != '0)) begin
            count_d = count_q - WD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = busy && (count_q == '0);

endmodule
`endif

// File: rtl/i2c_master_byte_seq.sv
// Byte-level I2C sequencer: turns one host byte request into bit-controller
// commands. Optional per-command watchdog under I2C_SEQ_TIMEOUT_EN.
module i2c_master_byte_seq
    import i2c_master_byte_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_al,
    output logic       timeout,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       bit_al
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_e;

    state_e     state_q,    state_d;
    logic [3:0] core_cmd_q, core_cmd_d;
    logic       core_txd_q, core_txd_d;
    logic       cmd_ack_q,  cmd_ack_d;
    logic       ack_out_q,  ack_out_d;
    logic [7:0] dout_q,     dout_d;
    logic [7:0] sr_q,       sr_d;
    logic [2:0] cnt_q,      cnt_d;
    logic       wr_q,       wr_d;
    logic       i2c_al_q;
    logic       go;
    logic       shift_in;
    logic [7:0] sr_shl;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic wd_load;
    logic wd_busy;
    logic wd_expired;
    logic timeout_q;
    logic timeout_d;
`endif

    assign go = (start | stop | read | write) & ~cmd_ack_q;

    // Shift register moves left; reads bring the slave bit in at the LSB.
    assign shift_in  = (state_q == ST_READ) ? core_rxd : 1'b0;
    assign sr_shl[0] = shift_in;
    for (genvar gi = 1; gi < 8; gi++) begin : g_sr_shift
        assign sr_shl[gi] = sr_q[gi-1];
    end

    always_comb begin
        state_d    = state_q;
        core_cmd_d = core_cmd_q;
        core_txd_d = core_txd_q;
        cmd_ack_d  = 1'b0;
        ack_out_d  = ack_out_q;
        dout_d     = dout_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;

        if (bit_al) begin
            state_d    = ST_IDLE;
            core_cmd_d = I2C_CMD_NOP;
            core_txd_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        sr_d       = din;
                        cnt_d      = 3'd7;
                        core_txd_d = 1'b0;
                        if (start) begin
                            state_d    = ST_START;
                            core_cmd_d = I2C_CMD_START;
                        end else if (read) begin
                            state_d    = ST_READ;
                            core_cmd_d = I2C_CMD_READ;
                            wr_d       = 1'b0;
                        end else if (write) begin
                            state_d    = ST_WRITE;
                            core_cmd_d = I2C_CMD_WRITE;
                            core_txd_d = din[7];
                            wr_d       = 1'b1;
                        end else begin
                            state_d    = ST_STOP;
                            core_cmd_d = I2C_CMD_STOP;
                        end
                    end
                end

                ST_START: begin
                    if (core_ack) begin
                        core_txd_d = 1'b0;
                        if (read) begin
                            state_d    = ST_READ;
                            core_cmd_d = I2C_CMD_READ;
                            wr_d       = 1'b0;
                        end else if (write) begin
                            state_d    = ST_WRITE;
                            core_cmd_d = I2C_CMD_WRITE;
                            core_txd_d = sr_q[7];
                            wr_d       = 1'b1;
                        end else if (stop) begin
                            state_d    = ST_STOP;
                            core_cmd_d = I2C_CMD_STOP;
                        end else begin
                            state_d    = ST_IDLE;
                            core_cmd_d = I2C_CMD_NOP;
                            cmd_ack_d  = 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (core_ack) begin
                        sr_d  = sr_shl;
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            // Ninth clock: read back the slave's ACK bit.
                            state_d    = ST_ACK;
                            core_cmd_d = I2C_CMD_READ;
                            core_txd_d = 1'b0;
                        end else begin
                            core_txd_d = sr_q[6];
                        end
                    end
                end

                ST_READ: begin
                    if (core_ack) begin
                        sr_d  = sr_shl;
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            state_d    = ST_ACK;
                            core_cmd_d = I2C_CMD_WRITE;
                            core_txd_d = ack_in;
                        end
                    end
                end

                ST_ACK: begin
                    if (core_ack) begin
                        if (wr_q) begin
                            ack_out_d = core_rxd;
                        end
                        dout_d     = sr_q;
                        core_txd_d = 1'b0;
                        if (stop) begin
                            state_d    = ST_STOP;
                            core_cmd_d = I2C_CMD_STOP;
                        end else begin
                            state_d    = ST_IDLE;
                            core_cmd_d = I2C_CMD_NOP;
                            cmd_ack_d  = 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (core_ack) begin
                        state_d    = ST_IDLE;
                        core_cmd_d = I2C_CMD_NOP;
                        cmd_ack_d  = 1'b1;
                    end
                end

                default: begin
                    state_d    = ST_IDLE;
                    core_cmd_d = I2C_CMD_NOP;
                    core_txd_d = 1'b0;
                end
            endcase

`ifdef I2C_SEQ_TIMEOUT_EN
            // A late core_ack in the expiry cycle still completes the bit.
            if (wd_expired && !core_ack) begin
                state_d    = ST_IDLE;
                core_cmd_d = I2C_CMD_NOP;
                core_txd_d = 1'b0;
                cmd_ack_d  = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            core_cmd_q <= I2C_CMD_NOP;
            core_txd_q <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            dout_q     <= 8'h00;
            sr_q       <= 8'h00;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            i2c_al_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_cmd_q <= core_cmd_d;
            core_txd_q <= core_txd_d;
            cmd_ack_q  <= cmd_ack_d;
            ack_out_q  <= ack_out_d;
            dout_q     <= dout_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            i2c_al_q   <= bit_al;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Every freshly issued bit command restarts the wait budget.
    assign wd_busy   = (state_q != ST_IDLE);
    assign wd_load   = is_bus_cmd(core_cmd_d) && ((state_q == ST_IDLE) || core_ack);
    assign timeout_d = wd_expired & ~core_ack & ~bit_al;

    i2c_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (wd_load),
        .busy    (wd_busy),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign core_cmd = core_cmd_q;
    assign core_txd = core_txd_q;
    assign cmd_ack  = cmd_ack_q;
    assign ack_out  = ack_out_q;
    assign dout     = dout_q;
    assign i2c_al   = i2c_al_q;

endmodule

// File: tb/tb_i2c_master_byte_seq.sv
// Directed self-checking bench for i2c_master_byte_seq with a behavioural
// bit-controller model that acks each command after a fixed delay.
`timescale 1ns/1ps
module tb_i2c_master_byte_seq;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, start, stop, read, write, ack_in;
    logic [7:0] din;
    logic       cmd_ack, ack_out, i2c_al, timeout;
    logic [7:0] dout;
    logic [3:0] core_cmd;
    logic       core_txd, core_ack, core_rxd, bit_al;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         ack_pulses = 0;
    bit         timeout_seen = 1'b0;
    bit         model_en   = 1'b1;
    int         ack_delay  = 20;
    logic [3:0] log_cmd[$];
    logic       log_txd[$];
    logic       rx_bits[$];
    logic [3:0] exp_cmd[$];
    int         pulses0, gap;
    bit         done, got;
    logic [7:0] rd_byte;

    always #5 clk = ~clk;

    i2c_master_byte_seq #(
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .read     (read),
        .write    (write),
        .ack_in   (ack_in),
        .din      (din),
        .cmd_ack  (cmd_ack),
        .ack_out  (ack_out),
        .dout     (dout),
        .i2c_al   (i2c_al),
        .timeout  (timeout),
        .core_cmd (core_cmd),
        .core_txd (core_txd),
        .core_ack (core_ack),
        .core_rxd (core_rxd),
        .bit_al   (bit_al)
    );

    task automatic check_value(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [63:0] pack_cmds(input logic [3:0] q[$]);
        logic [63:0] v = '0;
        foreach (q[i]) v = {v[59:0], q[i]};
        return v;
    endfunction

    function automatic logic [15:0] write_bits(input logic [3:0] c[$], input logic t[$]);
        logic [15:0] v = '0;
        foreach (c[i]) if (c[i] == CMD_WRITE) v = {v[14:0], t[i]};
        return v;
    endfunction

    // Bit-controller model: acks any pending command after ack_delay cycles.
    initial begin : bitctrl_model
        int wait_cnt;
        wait_cnt = 0;
        core_ack = 1'b0;
        core_rxd = 1'b0;
        forever begin
            @(negedge clk);
            core_ack = 1'b0;
            if (model_en && core_cmd != CMD_NOP) begin
                if (wait_cnt >= ack_delay - 1) begin
                    core_ack = 1'b1;
                    wait_cnt = 0;
                    log_cmd.push_back(core_cmd);
                    log_txd.push_back(core_txd);
                    if (core_cmd == CMD_READ)
                        core_rxd = (rx_bits.size() > 0) ? rx_bits.pop_front() : 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_ack) ack_pulses++;
        if (timeout) timeout_seen = 1'b1;
    end

    task automatic wait_cmd_ack(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ack) ok = 1'b1;
        end
        check_value(tag, ok, 1'b1);
    endtask

    task automatic run_request(input string tag, input logic s, input logic p, input logic r,
                               input logic w, input logic a, input logic [7:0] d,
                               input logic [3:0] first_cmd);
        int p0;
        p0 = ack_pulses;
        log_cmd.delete();
        log_txd.delete();
        @(negedge clk);
        start = s; stop = p; read = r; write = w; ack_in = a; din = d;
        @(negedge clk);
        check_value({tag, "_first_cmd"}, core_cmd, first_cmd);
        wait_cmd_ack({tag, "_done"});
        start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
        @(negedge clk);
        check_value({tag, "_ack_width"}, cmd_ack, 1'b0);
        check_value({tag, "_ack_count"}, ack_pulses - p0, 1);
        $display("req %s: din=%h cmds=%0d dout=%h ack_out=%b", tag, d, log_cmd.size(), dout, ack_out);
    endtask

    initial begin : global_guard
        #1ms;
        $display("FAIL global_guard: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
        ack_in = 1'b0; din = 8'h00; bit_al = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_core_cmd", core_cmd, CMD_NOP);
        check_value("rst_core_txd", core_txd, 1'b0);
        check_value("rst_cmd_ack",  cmd_ack,  1'b0);
        check_value("rst_ack_out",  ack_out,  1'b0);
        check_value("rst_dout",     dout,     8'h00);
        check_value("rst_i2c_al",   i2c_al,   1'b0);
        check_value("rst_timeout",  timeout,  1'b0);
        rst = 1'b0;

        // START + WRITE 0xA5 + STOP, slave ACKs
        rx_bits.delete(); rx_bits.push_back(1'b0);
        run_request("sws_a5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, CMD_START);
        exp_cmd = {};
        exp_cmd.push_back(CMD_START);
        for (int i = 0; i < 8; i++) exp_cmd.push_back(CMD_WRITE);
        exp_cmd.push_back(CMD_READ);
        exp_cmd.push_back(CMD_STOP);
        check_value("sws_a5_len",  log_cmd.size(), 11);
        check_value("sws_a5_cmds", pack_cmds(log_cmd), pack_cmds(exp_cmd));
        check_value("sws_a5_txd",  write_bits(log_cmd, log_txd), 16'h00A5);
        check_value("sws_a5_ack_out", ack_out, 1'b0);

        // READ + STOP with NACK, slave returns 0x3C
        rd_byte = 8'h3C;
        rx_bits.delete();
        for (int i = 7; i >= 0; i--) rx_bits.push_back(rd_byte[i]);
        run_request("rs_3c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, CMD_READ);
        exp_cmd = {};
        for (int i = 0; i < 8; i++) exp_cmd.push_back(CMD_READ);
        exp_cmd.push_back(CMD_WRITE);
        exp_cmd.push_back(CMD_STOP);
        check_value("rs_3c_len",  log_cmd.size(), 10);
        check_value("rs_3c_cmds", pack_cmds(log_cmd), pack_cmds(exp_cmd));
        check_value("rs_3c_ack_txd", (log_txd.size() > 8) ? log_txd[8] : 1'bx, 1'b1);
        check_value("rs_3c_dout", dout, 8'h3C);

        // Arbitration lost during the 4th write bit
        log_cmd.delete(); log_txd.delete(); rx_bits.delete();
        pulses0 = ack_pulses;
        @(negedge clk);
        start = 1'b1; stop = 1'b1; write = 1'b1; din = 8'h5A;
        got = 1'b0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (log_cmd.size() >= 4) got = 1'b1;
        end
        check_value("al_reach_bit4", got, 1'b1);
        repeat (3) @(negedge clk);
        check_value("al_cmd_before", core_cmd, CMD_WRITE);
        check_value("al_txd_bit4",   core_txd, 1'b1);
        bit_al = 1'b1;
        @(negedge clk);
        bit_al = 1'b0;
        start = 1'b0; stop = 1'b0; write = 1'b0;
        check_value("al_cmd_nop",  core_cmd, CMD_NOP);
        check_value("al_i2c_al",   i2c_al,   1'b1);
        check_value("al_no_ack",   cmd_ack,  1'b0);
        repeat (30) @(negedge clk);
        check_value("al_no_ack_later", ack_pulses - pulses0, 0);
        check_value("al_idle_cmd",     core_cmd, CMD_NOP);
        check_value("al_i2c_al_clear", i2c_al,   1'b0);
        $display("req al_5a: aborted after %0d cmds", log_cmd.size());

        // Reset in the middle of a read
        log_cmd.delete(); log_txd.delete(); rx_bits.delete();
        for (int i = 7; i >= 0; i--) rx_bits.push_back(rd_byte[i]);
        @(negedge clk);
        read = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (log_cmd.size() >= 3) got = 1'b1;
        end
        check_value("mr_reach_bit3", got, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1; read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_value("mr_core_cmd", core_cmd, CMD_NOP);
        check_value("mr_core_txd", core_txd, 1'b0);
        check_value("mr_cmd_ack",  cmd_ack,  1'b0);
        check_value("mr_dout",     dout,     8'h00);
        check_value("mr_ack_out",  ack_out,  1'b0);
        check_value("mr_i2c_al",   i2c_al,   1'b0);
        $display("req mid_rst: aborted after %0d cmds", log_cmd.size());

        // Plain write 0xFF, slave NACKs
        rx_bits.delete(); rx_bits.push_back(1'b1);
        run_request("w_ff", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, CMD_WRITE);
        check_value("w_ff_len", log_cmd.size(), 9);
        check_value("w_ff_txd", write_bits(log_cmd, log_txd), 16'h00FF);
        check_value("w_ff_last", (log_cmd.size() == 9) ? log_cmd[8] : 4'hx, CMD_READ);
        check_value("w_ff_ack_out", ack_out, 1'b1);

        // Back-to-back writes 0x01 then 0x80
        log_cmd.delete(); log_txd.delete(); rx_bits.delete();
        rx_bits.push_back(1'b0); rx_bits.push_back(1'b0);
        pulses0 = ack_pulses;
        @(negedge clk);
        write = 1'b1; din = 8'h01;
        wait_cmd_ack("b2b_first_done");
        din = 8'h80;
        gap = 0; got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            gap++;
            if (core_cmd == CMD_WRITE) got = 1'b1;
        end
        check_value("b2b_restart_gap", gap, 2);
        check_value("b2b_second_txd0", core_txd, 1'b1);
        wait_cmd_ack("b2b_second_done");
        write = 1'b0;
        @(negedge clk);
        check_value("b2b_len", log_cmd.size(), 18);
        check_value("b2b_txd", write_bits(log_cmd, log_txd), 16'h0180);
        check_value("b2b_ack_out", ack_out, 1'b0);
        check_value("b2b_pulses", ack_pulses - pulses0, 2);
        $display("req b2b_01_80: cmds=%0d ack_out=%b", log_cmd.size(), ack_out);

`ifdef I2C_SEQ_TIMEOUT_EN
        // Watchdog: model never acks
        model_en = 1'b0;
        pulses0 = ack_pulses;
        @(negedge clk);
        write = 1'b1; din = 8'h00;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (core_cmd != CMD_NOP) got = 1'b1;
        end
        check_value("to_cmd_issued", got, 1'b1);
        gap = 0; got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            gap++;
            if (timeout) got = 1'b1;
        end
        check_value("to_latency", gap, 51);
        check_value("to_cmd_nop", core_cmd, CMD_NOP);
        write = 1'b0;
        @(negedge clk);
        check_value("to_pulse_width", timeout, 1'b0);
        repeat (5) @(negedge clk);
        check_value("to_no_cmd_ack", ack_pulses - pulses0, 0);
        model_en = 1'b1;
        $display("req timeout: latency=%0d", gap);
`else
        check_value("timeout_never", timeout_seen, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
